// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Covers the reduced instruction set addi, lw, sw and bne.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_I   = 4'd2,
        WB_ALU   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        WB_MEM   = 4'd6,
        MEM_WR   = 4'd7,
        BRANCH   = 4'd8,
        HALT     = 4'd9
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // Every supported instruction needs only an add from the ALU.
    localparam logic [2:0] ALU_ADD = 3'b000;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier for the control sequencer.
// Only the opcode and funct3 fields are needed to pick the next state.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_addi,
    output logic        is_bne,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Register and immediate fields belong to the datapath, not to control.
    assign unused_instr_fields = ^{instr[31:15], instr[11:7]};

    // Classify the instruction; anything outside the supported set is illegal.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_addi = 1'b0;
        is_bne  = 1'b0;
        case (opcode)
            OP_LOAD:   is_lw   = 1'b1;
            OP_STORE:  is_sw   = 1'b1;
            OP_IMM:    is_addi = (funct3 == F3_ADDI);
            OP_BRANCH: is_bne  = (funct3 == F3_BNE);
            default:   ;
        endcase
        illegal = !(is_lw || is_sw || is_addi || is_bne);
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the reduced RV32I core.
// Fetch and load/store share one memory port through a MemReq/mem_ready
// handshake; an optional wait timeout sets the sticky mem_err flag.
// Build option: define CTRL_ILLEGAL_HALT_EN to park in HALT on an illegal
// opcode; otherwise an illegal opcode behaves as a non-retiring NOP.
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 EQ,
    input  logic                 mem_ready,
    output logic                 MemReq,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCsrc,
    output logic                 RegWrite,
    output logic [2:0]           ALUctrl,
    output logic                 ALUsrc,
    output logic                 ImmSrc,
    output logic                 ResultSrc,
    output logic [CNT_WIDTH-1:0] instret,
    output logic                 mem_err
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

    ctrl_state_t   state;
    ctrl_state_t   state_next;
    logic [TW-1:0] wait_cnt;
    logic          mem_wait;
    logic          timeout_hit;
    logic          retire;
    logic          is_lw;
    logic          is_sw;
    logic          is_addi;
    logic          is_bne;
    logic          illegal;

    ctrl_decode u_decode (
        .instr   (instr),
        .is_lw   (is_lw),
        .is_sw   (is_sw),
        .is_addi (is_addi),
        .is_bne  (is_bne),
        .illegal (illegal)
    );

    // The timeout fires on the last allowed wait cycle unless memory answers then.
    assign mem_wait    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timeout_hit = (MEM_TIMEOUT > 0) && mem_wait && !mem_ready && (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    // Next-state and Moore outputs; PCWrite in BRANCH and the fetch writes follow inputs.
    always_comb begin
        state_next = state;
        MemReq     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCsrc      = 1'b0;
        RegWrite   = 1'b0;
        ALUctrl    = ALU_ADD;
        ALUsrc     = 1'b0;
        ImmSrc     = 1'b0;
        ResultSrc  = 1'b0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                MemReq = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_lw || is_sw)  state_next = MEM_ADDR;
                else if (is_addi)    state_next = EXEC_I;
                else if (is_bne)     state_next = BRANCH;
                else if (illegal) begin
`ifdef CTRL_ILLEGAL_HALT_EN
                    state_next = HALT;
`else
                    state_next = FETCH;
`endif
                end
            end
            EXEC_I: begin
                ALUsrc     = 1'b1;
                state_next = WB_ALU;
            end
            WB_ALU: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                ALUsrc     = 1'b1;
                state_next = is_lw ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready)        state_next = WB_MEM;
                else if (timeout_hit) state_next = FETCH;
            end
            WB_MEM: begin
                RegWrite   = 1'b1;
                ResultSrc  = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                MemReq   = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end else if (timeout_hit) begin
                    state_next = FETCH;
                end
            end
            BRANCH: begin
                ImmSrc     = 1'b1;
                PCsrc      = 1'b1;
                PCWrite    = !EQ;
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Memory wait counter; restarts on every state change and after a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                               wait_cnt <= '0;
        else if (!mem_wait || timeout_hit || state_next != state) wait_cnt <= '0;
        else                                                      wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky memory timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           mem_err <= 1'b0;
        else if (timeout_hit) mem_err <= 1'b1;
    end

    // Retired instruction counter, wrapping naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret <= '0;
        else if (retire) instret <= instret + 1'b1;
    end

endmodule
